// File: rtl/sync_grant_ctrl.sv
// Registered one-hot grant stage with bus-turnaround gap and grant counter.
// Build with SYNC_GRANT_TIMEOUT_EN to enable the forced-release hold timeout.
module sync_grant_ctrl #(
  parameter int unsigned n   = 32,
  parameter int unsigned IW  = $clog2(n),
  parameter int unsigned CW  = 16,
  parameter int unsigned TMO = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [n-1:0]  req,
  input  logic [n-1:0]  sel,
  input  logic          done,
  output logic [n-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          busy,
  output logic [CW-1:0] gnt_cnt,
  output logic          timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [n-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] id_q, id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;

  logic [n-1:0]  cand;
  logic          cand_any;
  logic [IW-1:0] pick_id;
  logic          rel;
  logic          tmo_hit;

  assign cand     = req & sel;
  assign cand_any = |cand;
  assign rel      = done | ~req[id_q];

  // Descending scan so the lowest set index wins.
  always_comb begin
    pick_id = '0;
    for (int i = int'(n) - 1; i >= 0; i--) begin
      if (cand[i]) pick_id = IW'(i);
    end
  end

`ifdef SYNC_GRANT_TIMEOUT_EN
  localparam int unsigned HW = $clog2(TMO + 1);

  logic [HW-1:0] hold_q, hold_d;

  assign tmo_hit = (hold_q == HW'(TMO - 1));

  always_comb begin
    hold_d = hold_q;
    unique case (state_q)
      S_IDLE:  hold_d = '0;
      S_GRANT: hold_d = hold_q + 1'b1;
      S_GAP:   hold_d = '0;
      default: hold_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo = ^TMO;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cand_any) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (rel || tmo_hit) state_d = S_GAP;
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    gnt_d = gnt_q;
    id_d  = id_q;
    cnt_d = cnt_q;
    tmo_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (cand_any) begin
          gnt_d[pick_id] = 1'b1;
          id_d           = pick_id;
          cnt_d          = cnt_q + 1'b1;
        end
      end
      S_GRANT: begin
        // A real release outranks the timeout, which then stays silent.
        if (rel || tmo_hit) begin
          gnt_d = '0;
          tmo_d = ~rel & tmo_hit;
        end
      end
      S_GAP: begin
        gnt_d = '0;
      end
      default: begin
        gnt_d = '0;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign busy    = (state_q == S_GRANT);
  assign gnt_cnt = cnt_q;
  assign timeout = tmo_q;

endmodule

// File: doc/sync_grant_ctrl.md
Name: sync_grant_ctrl

Overview:
- Registered grant stage directly downstream of the request-decode block in sync_lib.
- Takes the decoded selection vector (sel) and the raw client request lines, and issues a single registered one-hot grant.
- Holds the grant until the owner signals done or drops its request, then inserts a one-cycle bus-turnaround gap.
- Provides a grant counter and an optional hold timeout.

Parameters:
- n, 32, number of clients; equals the decode block's n.
- IW, $clog2(n), width of the grant index.
- CW, 16, width of the grant-event counter.
- TMO, 256, maximum grant hold cycles; used only with the timeout feature; must be ≥ 2.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  n  client request lines, level, active-high.
- sel  input  n  decoded selection from the request-decode block; nominally one-hot.
- done  input  1  owner pulse ending the current transfer.
- gnt  output  n  registered one-hot grant.
- gnt_id  output  IW  index of the granted client; valid while busy=1.
- busy  output  1  high while a grant is held.
- gnt_cnt  output  CW  number of grants issued; wraps.
- timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (async assert, sync deassert edge): state=IDLE, gnt=0, gnt_id=0, busy=0, gnt_cnt=0, timeout=0, hold counter=0.
- States: IDLE, GRANT, GAP.
- IDLE:
  - cand = req & sel.
  - If cand≠0, pick the lowest set index i, even if sel is not one-hot.
  - Next edge: gnt=onehot(i), gnt_id=i, busy=1, gnt_cnt+=1, state→GRANT.
  - Latency is 1 cycle from sampled req&sel to gnt.
  - If cand=0, remain in IDLE; gnt stays 0.
- GRANT:
  - gnt, gnt_id and busy are stable; sel and other requests are ignored.
  - Release condition: done=1, or req[gnt_id]=0.
  - On release, next edge: gnt=0, busy=0, state→GAP.
  - done and a request drop in the same cycle count as one release.
- GAP:
  - Exactly one cycle with gnt=0; no sampling; state→IDLE.
  - Minimum spacing between successive grants is therefore 3 cycles (GRANT, GAP, IDLE-sample), even to the same client.
- done outside GRANT is ignored.
- gnt_cnt wraps from 2^CW−1 to 0 with no flag.
- An X/unknown sel is not guarded; the upstream block guarantees a defined sel after reset.
- Reset mid-grant drops gnt immediately, asynchronously; no done is required.
- Invariant: gnt is always zero or one-hot.
- Invariant: busy == |gnt.

Optional Feature:
- Macro: SYNC_GRANT_TIMEOUT_EN.
- Defined:
  - A hold counter of $clog2(TMO+1) bits clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches TMO−1 with no release, the next edge forces release (gnt=0, state→GAP) and pulses timeout=1 for one cycle.
  - A release and the timeout in the same cycle count as a normal release; timeout stays 0.
- Undefined: the counter is absent, timeout is tied to 0, and a grant is held indefinitely.

Test Plan:
1. Reset, then req=0x0000_0010 and sel=0x0000_0010 → after 1 cycle: gnt=0x10, gnt_id=4, busy=1, gnt_cnt=1.
2. Hold req[4] for 10 cycles, then pulse done → gnt=0 next cycle; one GAP cycle; a new grant is possible no earlier than 3 cycles after done.
3. req=0x0000_00C0 and sel=0x0000_00C0 (malformed sel) → gnt=0x40, gnt_id=6; then drop req[6] → release; req[7] is granted after the GAP.
4. During GRANT on client 2, change sel to 0x8 and raise req[3] → gnt stays 0x4 until release, then client 3 is granted.
5. Assert rst_n=0 mid-grant, asynchronously between edges → gnt, busy and gnt_cnt are 0 immediately; block restarts in IDLE.
6. With SYNC_GRANT_TIMEOUT_EN and TMO=8, hold req[0] with no done → gnt drops after 8 GRANT cycles and timeout pulses for 1 cycle; without the macro, gnt is held and timeout stays 0.
